// File: rtl/traffic_request_sequencer.sv
// Traffic request sequencer: debounces four approach sensors, latches demand,
// and grants approaches round-robin to the light controller with bounded dwell.

// Per-approach sensor debouncer: toggles its level after DEB_CYCLES
// consecutive disagreeing samples and flags the cycle after a rising level.
module traffic_request_sequencer_lane #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic res_n,
   input  logic sensor_i,
   output logic deb_o,
   output logic rise_o
);
   localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

   logic [3:0] cnt_q, cnt_d;
   logic       deb_q, deb_d;
   logic       deb_d1_q;

   // Count consecutive disagreeing samples; flip the level when the run completes.
   always_comb begin
      cnt_d = 4'd0;
      deb_d = deb_q;
      if (sensor_i != deb_q) begin
         if (cnt_q == DEB_LAST) begin
            deb_d = ~deb_q;
            cnt_d = 4'd0;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   // Debounce state plus a delayed copy of the level for edge detection.
   always_ff @(posedge clk) begin
      if (!res_n) begin
         cnt_q    <= 4'd0;
         deb_q    <= 1'b0;
         deb_d1_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         deb_q    <= deb_d;
         deb_d1_q <= deb_q;
      end
   end

   assign deb_o  = deb_q;
   assign rise_o = deb_q & ~deb_d1_q;
endmodule

module traffic_request_sequencer #(
   parameter int DEB_CYCLES = 4,
   parameter int DWELL_W    = 8,
   parameter int MIN_DWELL  = 16,
   parameter int MAX_DWELL  = 64
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic [3:0] sensor,
   output logic [1:0] req_code,
   output logic       req_en,
   output logic [3:0] pending,
   output logic       busy
);
   localparam logic [DWELL_W-1:0] MIN_LAST = DWELL_W'(MIN_DWELL - 1);
   localparam logic [DWELL_W-1:0] MAX_LAST = DWELL_W'(MAX_DWELL - 1);

   typedef enum logic [1:0] {IDLE, SERVE, SWITCH} state_t;

   state_t             state_q, state_d;
   logic [1:0]         cur_q, cur_d;
   logic [1:0]         last_q, last_d;
   logic [3:0]         pend_q, pend_d;
   logic [DWELL_W-1:0] timer_q, timer_d;

   logic [3:0] deb, rise;
   logic [1:0] pick;
   logic [1:0] idx;
   logic       others;

   for (genvar i = 0; i < 4; i++) begin : g_lane
      traffic_request_sequencer_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
         .clk      (clk),
         .res_n    (res_n),
         .sensor_i (sensor[i]),
         .deb_o    (deb[i]),
         .rise_o   (rise[i])
      );
   end

   // Round-robin pick: scan downward so the nearest lane after last_q wins;
   // the last-granted lane itself comes up only when nothing else is pending.
   always_comb begin
      pick = last_q;
      idx  = last_q;
      for (int k = 4; k >= 1; k--) begin
         idx = last_q + 2'(k);
         if (pend_q[idx]) pick = idx;
      end
   end

   assign others = |(pend_q & ~(4'b0001 << cur_q));

   // Grant FSM next-state: new demand always latches; the served lane's
   // demand is only touched when its grant ends.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      last_d  = last_q;
      timer_d = timer_q;
      pend_d  = pend_q | rise;
      case (state_q)
         IDLE, SWITCH: begin
            if (|pend_q) begin
               state_d = SERVE;
               cur_d   = pick;
               timer_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         SERVE: begin
            if (timer_q >= MIN_LAST) begin
               if (others || timer_q == MAX_LAST) begin
                  // Hand over: re-queue remaining demand behind the others.
                  state_d        = SWITCH;
                  pend_d[cur_q]  = deb[cur_q];
                  last_d         = cur_q;
               end else if (!deb[cur_q]) begin
                  state_d        = IDLE;
                  pend_d[cur_q]  = 1'b0;
                  last_d         = cur_q;
               end else begin
                  timer_d = timer_q + DWELL_W'(1);
               end
            end else begin
               timer_d = timer_q + DWELL_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grant FSM registers; reset gives approach 0 first priority.
   always_ff @(posedge clk) begin
      if (!res_n) begin
         state_q <= IDLE;
         cur_q   <= 2'd0;
         last_q  <= 2'd3;
         pend_q  <= 4'd0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         pend_q  <= pend_d;
         timer_q <= timer_d;
      end
   end

   assign req_code = cur_q;
   assign req_en   = (state_q == SERVE);
   assign busy     = (state_q != IDLE);
   assign pending  = pend_q;
endmodule

// File: tb/tb_traffic_request_sequencer.sv
// Bench for traffic_request_sequencer: vector table, directed scenarios and
// randomized sensor traffic against a rule-level reference model.
module tb_traffic_request_sequencer;
   localparam int DEB = 4;
   localparam int MIN = 16;
   localparam int MAX = 64;

   logic       clk, res_n;
   logic [3:0] sensor;
   logic [1:0] req_code;
   logic       req_en, busy;
   logic [3:0] pending;

   int checks = 0, failures = 0;

   traffic_request_sequencer dut (
      .clk(clk), .res_n(res_n), .sensor(sensor),
      .req_code(req_code), .req_en(req_en), .pending(pending), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int         m_cnt[4];
   bit         m_lvl[4];
   bit         m_lvl_old[4];
   bit [3:0]   m_pend;
   int         m_last, m_cur, m_held;
   bit         m_on, m_gap;
   bit [1:0]   m_code;

   function automatic void model_step(input bit r, input logic [3:0] s);
      bit [3:0] np;
      bit others, found;
      int j;
      if (!r) begin
         for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_lvl[i] = 0; m_lvl_old[i] = 0;
         end
         m_pend = 0; m_last = 3; m_cur = 0; m_held = 0;
         m_on = 0; m_gap = 0; m_code = 0;
         return;
      end
      np = m_pend;
      for (int i = 0; i < 4; i++)
         if (m_lvl[i] && !m_lvl_old[i]) np[i] = 1'b1;
      if (m_on) begin
         if (m_held >= MIN - 1) begin
            others = 0;
            for (int i = 0; i < 4; i++)
               if (i != m_cur && m_pend[i]) others = 1;
            if (others || m_held == MAX - 1) begin
               m_on = 0; m_gap = 1; np[m_cur] = m_lvl[m_cur]; m_last = m_cur;
            end else if (!m_lvl[m_cur]) begin
               m_on = 0; np[m_cur] = 1'b0; m_last = m_cur;
            end else m_held++;
         end else m_held++;
      end else begin
         m_gap = 0;
         if (m_pend != 0) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
               j = (m_last + k) % 4;
               if (!found && m_pend[j]) begin m_cur = j; found = 1; end
            end
            m_on = 1; m_held = 0; m_code = 2'(m_cur);
         end
      end
      m_pend = np;
      for (int i = 0; i < 4; i++) begin
         m_lvl_old[i] = m_lvl[i];
         if (s[i] != m_lvl[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] == DEB) begin m_lvl[i] = ~m_lvl[i]; m_cnt[i] = 0; end
         end else m_cnt[i] = 0;
      end
   endfunction

   // ---------------- checking / tracking ----------------
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
      end
   endtask

   bit en_prev, seen_run;
   int run_code, run_len, gap_len, tick_n;
   int q_codes[$], q_lens[$], q_gaps[$];

   task automatic clear_track();
      en_prev = 0; seen_run = 0; run_len = 0; gap_len = 0; tick_n = 0;
      q_codes.delete(); q_lens.delete(); q_gaps.delete();
   endtask

   task automatic tick(input bit r, input logic [3:0] s);
      res_n = r; sensor = s;
      @(posedge clk);
      model_step(r, s);
      #1;
      tick_n++;
      check("model", {req_en, req_code, pending, busy}, {m_on, m_code, m_pend, m_on | m_gap});
      if (req_en) begin
         if (!en_prev) begin
            if (seen_run) q_gaps.push_back(gap_len);
            run_code = req_code; run_len = 0; seen_run = 1;
         end
         run_len++;
      end else begin
         if (en_prev) begin
            q_codes.push_back(run_code); q_lens.push_back(run_len); gap_len = 0;
         end
         gap_len++;
      end
      en_prev = req_en;
   endtask

   task automatic do_reset(input logic [3:0] s);
      for (int i = 0; i < 3; i++) tick(1'b0, s);
      clear_track();
   endtask

   typedef struct {
      bit r; logic [3:0] s;
      bit en; logic [1:0] code; logic [3:0] pend; bit busy;
   } vec_t;
   vec_t tbl[10];

   int first_pend, first_en, first_code, lim;
   bit saw_pend, saw_en;
   int exp_rr[6];
   logic [3:0] rs;

   initial begin
      res_n = 1'b0; sensor = 4'd0;
      // reset with all sensors high, then release: grant 0 after DEB+2 edges
      for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 4'hF, 1'b0, 2'd0, 4'h0, 1'b0};
      for (int i = 3; i < 7; i++) tbl[i] = '{1'b1, 4'hF, 1'b0, 2'd0, 4'h0, 1'b0};
      tbl[7] = '{1'b1, 4'hF, 1'b0, 2'd0, 4'hF, 1'b0};
      tbl[8] = '{1'b1, 4'hF, 1'b1, 2'd0, 4'hF, 1'b1};
      tbl[9] = '{1'b1, 4'hF, 1'b1, 2'd0, 4'hF, 1'b1};
      for (int i = 0; i < 10; i++) begin
         tick(tbl[i].r, tbl[i].s);
         check("vec", {req_en, req_code, pending, busy},
               {tbl[i].en, tbl[i].code, tbl[i].pend, tbl[i].busy});
      end

      // single lane
      do_reset(4'h0);
      first_pend = -1; first_en = -1; first_code = -1;
      for (int i = 0; i < 50; i++) begin
         tick(1'b1, (i < 30) ? 4'b0100 : 4'b0000);
         if (pending[2] && first_pend < 0) first_pend = tick_n;
         if (req_en && first_en < 0) begin first_en = tick_n; first_code = req_code; end
      end
      check("single_pend_edge", 8'(first_pend), 8'(DEB + 1));
      check("single_en_edge", 8'(first_en), 8'(DEB + 2));
      check("single_code", 8'(first_code), 8'd2);
      check("single_runs", 8'(q_lens.size()), 8'd1);
      if (q_lens.size() > 0) begin
         check("single_min", 8'(q_lens[0] >= MIN), 8'd1);
         check("single_len", 8'(q_lens[0]), 8'd29);
      end
      check("single_final", {req_en, pending, busy}, 8'd0);

      // glitch rejection
      do_reset(4'h0);
      saw_pend = 0; saw_en = 0;
      for (int r = 0; r < 5; r++)
         for (int i = 0; i < 4; i++) begin
            tick(1'b1, (i < 3) ? 4'b0010 : 4'b0000);
            if (pending[1]) saw_pend = 1;
            if (req_en) saw_en = 1;
         end
      check("glitch_pend", 8'(saw_pend), 8'd0);
      check("glitch_en", 8'(saw_en), 8'd0);

      // round-robin
      do_reset(4'h0);
      exp_rr = '{0, 1, 3, 0, 1, 3};
      for (int i = 0; i < 120; i++) tick(1'b1, 4'b1011);
      check("rr_count", 8'(q_codes.size()), 8'd6);
      for (int i = 0; i < 6 && i < q_codes.size(); i++) begin
         check("rr_code", 8'(q_codes[i]), 8'(exp_rr[i]));
         check("rr_len", 8'(q_lens[i]), 8'(MIN));
      end
      for (int i = 0; i < 5 && i < q_gaps.size(); i++) check("rr_gap", 8'(q_gaps[i]), 8'd1);

      // max dwell
      do_reset(4'h0);
      for (int i = 0; i < 200; i++) tick(1'b1, 4'b0001);
      check("max_runs", 8'(q_codes.size() >= 2), 8'd1);
      for (int i = 0; i < 2 && i < q_codes.size(); i++) begin
         check("max_code", 8'(q_codes[i]), 8'd0);
         check("max_len", 8'(q_lens[i]), 8'(MAX));
      end
      if (q_gaps.size() > 0) check("max_gap", 8'(q_gaps[0]), 8'd1);

      // mid-grant reset on lane 3
      do_reset(4'h0);
      for (int i = 0; i < 16; i++) tick(1'b1, 4'b1000);
      check("mid_granted", {req_en, req_code}, 8'b111);
      tick(1'b0, 4'b1000);
      check("mid_reset", {req_en, pending, busy}, 8'd0);
      clear_track();
      lim = 0;
      while (!req_en && lim < 20) begin tick(1'b1, 4'b1000); lim++; end
      check("mid_regrant", 8'(lim), 8'(DEB + 2));
      check("mid_code", 8'(req_code), 8'd3);

      // randomized traffic against the model
      do_reset(4'h0);
      rs = 4'h0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) rs[$urandom_range(3)] ^= 1'b1;
         if ($urandom_range(4) == 0 && $urandom_range(1) == 0) rs = rs ^ 4'(1 << $urandom_range(3));
         tick(($urandom_range(599) != 0), rs);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
